// File: rtl/vec_reduce_unit.sv
// vec_reduce_unit: folds one NUM_ELEMS-lane vector into a scalar (SUM / signed MAX / signed MIN / OR).
// Latency: OutValid is first high NUM_ELEMS-1 edges after the accepting edge; one lane per clock.
// Backpressure: InReady is high only in IDLE; the result is held in DONE until OutReady, for as long as needed.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   InValid/InReady     vector input handshake; InVec carries the lanes, RedOp selects the fold
//   OutValid/OutReady   scalar output handshake; OutResult is the scalar, OutZero flags a zero result
//   Busy                high while a vector is being folded or its result is waiting
module vec_reduce_unit #(
   parameter int NUM_ELEMS  = 8,
   parameter int ELEM_WIDTH = 32,
   parameter int REG_WIDTH  = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  InValid,
   output logic                  InReady,
   input  logic [REG_WIDTH-1:0]  InVec,
   input  logic [1:0]            RedOp,
   output logic                  OutValid,
   input  logic                  OutReady,
   output logic [ELEM_WIDTH-1:0] OutResult,
   output logic                  OutZero,
   output logic                  Busy
);

   localparam int               IDX_W     = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_ELEMS - 1);
   localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'((NUM_ELEMS > 1) ? 1 : 0);

   localparam logic [1:0] OP_SUM = 2'b00;
   localparam logic [1:0] OP_MAX = 2'b01;
   localparam logic [1:0] OP_MIN = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t                state;
   logic [REG_WIDTH-1:0]  vec_q;
   logic [1:0]            op_q;
   logic [IDX_W-1:0]      idx;
   logic [ELEM_WIDTH-1:0] acc;

   logic                  in_ready_q;
   logic                  out_valid_q;
   logic                  busy_q;
   logic [ELEM_WIDTH-1:0] out_result_q;
   logic                  out_zero_q;

   logic [ELEM_WIDTH-1:0] lane_arr [NUM_ELEMS];
   logic [ELEM_WIDTH-1:0] lane_cur;
   logic [ELEM_WIDTH-1:0] acc_next;
   logic [ELEM_WIDTH-1:0] lane0_in;

   // Lanes are read from the captured copy so upstream may change InVec after acceptance.
   for (genvar g = 0; g < NUM_ELEMS; g++) begin : g_lane
      assign lane_arr[g] = vec_q[g*ELEM_WIDTH +: ELEM_WIDTH];
   end

   assign lane0_in = InVec[ELEM_WIDTH-1:0];

   always_comb begin
      lane_cur = lane_arr[idx];
      acc_next = acc;
      case (op_q)
         OP_SUM:  acc_next = acc + lane_cur;  // carry-out dropped: modulo 2^ELEM_WIDTH
         OP_MAX:  acc_next = ($signed(lane_cur) > $signed(acc)) ? lane_cur : acc;
         OP_MIN:  acc_next = ($signed(lane_cur) < $signed(acc)) ? lane_cur : acc;
         default: acc_next = acc | lane_cur;
      endcase
   end

   // Every output is its own flop, so OutReady never reaches InReady combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         vec_q        <= '0;
         op_q         <= '0;
         idx          <= '0;
         acc          <= '0;
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         out_result_q <= '0;
         out_zero_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (InValid && in_ready_q) begin
                  vec_q      <= InVec;
                  op_q       <= RedOp;
                  acc        <= lane0_in;
                  idx        <= FIRST_IDX;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  if (NUM_ELEMS == 1) begin
                     state        <= ST_DONE;
                     out_valid_q  <= 1'b1;
                     out_result_q <= lane0_in;
                     out_zero_q   <= (lane0_in == '0);
                  end else begin
                     state <= ST_ACCUM;
                  end
               end
            end
            ST_ACCUM: begin
               acc <= acc_next;
               if (idx == LAST_IDX) begin
                  // Result registers load from the fold of the final lane on this same edge.
                  state        <= ST_DONE;
                  out_valid_q  <= 1'b1;
                  out_result_q <= acc_next;
                  out_zero_q   <= (acc_next == '0);
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            ST_DONE: begin
               if (OutReady) begin
                  // OutResult deliberately keeps its value after the handshake.
                  state       <= ST_IDLE;
                  idx         <= '0;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
                  out_zero_q  <= 1'b0;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state       <= ST_IDLE;
               idx         <= '0;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               out_zero_q  <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign InReady   = in_ready_q;
   assign OutValid  = out_valid_q;
   assign Busy      = busy_q;
   assign OutResult = out_result_q;
   assign OutZero   = out_zero_q;

endmodule

// File: tb/tb_vec_reduce_unit.sv
// tb_vec_reduce_unit: directed vectors with hand-computed results for vec_reduce_unit.
// Inputs are driven 1 ns after the rising edge; outputs are sampled at the same point.
// Covers reset state, all four folds, wrap, stall under backpressure, back-to-back and async reset.
`timescale 1ns/1ps
module tb_vec_reduce_unit;

   localparam int NE = 8;
   localparam int EW = 32;
   localparam int RW = 256;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b0;
   logic          InValid  = 1'b0;
   logic          InReady;
   logic [RW-1:0] InVec    = '0;
   logic [1:0]    RedOp    = 2'b00;
   logic          OutValid;
   logic          OutReady = 1'b0;
   logic [EW-1:0] OutResult;
   logic          OutZero;
   logic          Busy;

   int n_vec    = 0;
   int n_miscmp = 0;
   int k;
   logic got1;

   logic [RW-1:0] v_seq, v_mix, v_wrap, v_onehot, v_zero;

   always #5 clk = ~clk;

   vec_reduce_unit #(.NUM_ELEMS(NE), .ELEM_WIDTH(EW), .REG_WIDTH(RW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .InValid   (InValid),
      .InReady   (InReady),
      .InVec     (InVec),
      .RedOp     (RedOp),
      .OutValid  (OutValid),
      .OutReady  (OutReady),
      .OutResult (OutResult),
      .OutZero   (OutZero),
      .Busy      (Busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [RW-1:0] pack8(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
      return {a7, a6, a5, a4, a3, a2, a1, a0};
   endfunction

   // Presents a vector, waits (bounded) for InReady, returns 1 ns after the accepting edge.
   task automatic send(input logic [RW-1:0] v, input logic [1:0] op, input string tag);
      int w;
      w       = 0;
      InVec   = v;
      RedOp   = op;
      InValid = 1'b1;
      while (!InReady && w < 40) begin
         @(posedge clk); #1;
         w++;
      end
      check({tag, "/rdy"}, 32'(InReady), 32'd1);
      @(posedge clk); #1;
      InValid = 1'b0;
      RedOp   = ~op;
      InVec   = ~v;
   endtask

   // Called 1 ns after the accepting edge; counts edges until OutValid.
   task automatic wait_result(input logic [31:0] exp, input logic exp_zero, input string tag);
      int lat;
      lat = 0;
      while (!OutValid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "/lat"}, 32'(lat), 32'(NE - 1));
      check({tag, "/res"}, OutResult, exp);
      check({tag, "/zero"}, 32'(OutZero), 32'(exp_zero));
   endtask

   task automatic run(input logic [RW-1:0] v, input logic [1:0] op, input logic [31:0] exp,
                      input logic exp_zero, input string tag);
      OutReady = 1'b1;
      send(v, op, tag);
      wait_result(exp, exp_zero, tag);
      @(posedge clk); #1;
      check({tag, "/one_cycle"}, 32'(OutValid), 32'd0);
      check({tag, "/rdy_back"}, 32'(InReady), 32'd1);
      check({tag, "/held"}, OutResult, exp);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      v_seq    = pack8(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8);
      v_mix    = pack8(32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h7FFFFFFF,
                       32'd0, 32'd3, 32'hFFFFFFF9, 32'd2);
      v_wrap   = pack8(32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      v_onehot = pack8(32'h01, 32'h02, 32'h04, 32'h08, 32'h10, 32'h20, 32'h40, 32'h80);
      v_zero   = '0;

      // Reset state
      #12;
      check("rst/in_ready", 32'(InReady), 32'd1);
      check("rst/out_valid", 32'(OutValid), 32'd0);
      check("rst/busy", 32'(Busy), 32'd0);
      check("rst/result", OutResult, 32'd0);
      check("rst/zero", 32'(OutZero), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Folds
      run(v_seq,    2'b00, 32'd36,         1'b0, "sum_seq");
      run(v_mix,    2'b01, 32'h7FFFFFFF,   1'b0, "max_mix");
      run(v_mix,    2'b10, 32'h80000000,   1'b0, "min_mix");
      run(v_mix,    2'b00, 32'd1,          1'b0, "sum_mix");
      run(v_wrap,   2'b00, 32'd0,          1'b1, "sum_wrap");
      run(v_onehot, 2'b11, 32'h000000FF,   1'b0, "or_onehot");
      run(v_mix,    2'b11, 32'hFFFFFFFF,   1'b0, "or_mix");

      // Backpressure: stall in DONE for 20 cycles, second vector offered mid-stall
      OutReady = 1'b0;
      send(v_seq, 2'b00, "bp_a");
      wait_result(32'd36, 1'b0, "bp_a");
      for (int c = 0; c < 20; c++) begin
         if (c == 5) begin
            InVec   = v_onehot;
            RedOp   = 2'b11;
            InValid = 1'b1;
         end
         @(posedge clk); #1;
         check("bp/hold_res", OutResult, 32'd36);
         check("bp/hold_rdy", 32'(InReady), 32'd0);
         check("bp/hold_vld", 32'(OutValid), 32'd1);
      end
      OutReady = 1'b1;
      @(posedge clk); #1;
      check("bp/rdy_after", 32'(InReady), 32'd1);
      check("bp/vld_drop", 32'(OutValid), 32'd0);
      @(posedge clk); #1;
      check("bp/b_accepted", 32'(Busy), 32'd1);
      InValid = 1'b0;
      RedOp   = 2'b00;
      wait_result(32'h000000FF, 1'b0, "bp_b");
      @(posedge clk); #1;

      // Back-to-back: InValid held high across two vectors
      OutReady = 1'b1;
      InVec    = v_seq;
      RedOp    = 2'b00;
      InValid  = 1'b1;
      check("b2b/rdy0", 32'(InReady), 32'd1);
      @(posedge clk); #1;
      InVec = v_mix;
      RedOp = 2'b01;
      k     = 0;
      got1  = 1'b0;
      while (!InReady && k < 40) begin
         if (OutValid) begin
            check("b2b/res1", OutResult, 32'd36);
            got1 = 1'b1;
         end
         @(posedge clk); #1;
         k++;
      end
      check("b2b/saw_res1", 32'(got1), 32'd1);
      check("b2b/spacing", 32'(k + 1), 32'(NE + 1));
      @(posedge clk); #1;
      InValid = 1'b0;
      RedOp   = 2'b10;
      InVec   = '0;
      wait_result(32'h7FFFFFFF, 1'b0, "b2b_2");
      @(posedge clk); #1;

      // Async reset in the middle of a SUM (idx = 4)
      send(v_seq, 2'b00, "rst_mid");
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_mid/busy", 32'(Busy), 32'd0);
      check("rst_mid/in_ready", 32'(InReady), 32'd1);
      check("rst_mid/out_valid", 32'(OutValid), 32'd0);
      check("rst_mid/result", OutResult, 32'd0);
      check("rst_mid/zero", 32'(OutZero), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_mid/no_output", 32'(OutValid), 32'd0);
      run(v_zero, 2'b00, 32'd0, 1'b1, "rst_zero");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule

// File: doc/vec_reduce_unit.md
Name: vec_reduce_unit

Overview:
- Sequential reduction stage directly downstream of the vector ALU.
- Accepts one 256-bit ALU Result vector (8 x 32-bit lanes) and folds the lanes into one 32-bit scalar: sum, signed max, signed min, or bitwise OR.
- Processes one lane per clock.
- Uses valid/ready handshakes on both sides so the scalar can feed a scalar writeback path or branch logic.

Parameters:
- NUM_ELEMS, 8: number of lanes per vector; must be at least 1.
- ELEM_WIDTH, 32: width of each lane and of the result.
- REG_WIDTH, 256: input vector width; must equal NUM_ELEMS*ELEM_WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- InValid  input  1  upstream has a vector on InVec.
- InReady  output  1  block can accept a vector.
- InVec  input  REG_WIDTH  vector to reduce; lane i is InVec[i*ELEM_WIDTH +: ELEM_WIDTH].
- RedOp  input  2  operation select: 00 SUM, 01 signed MAX, 10 signed MIN, 11 OR.
- OutValid  output  1  OutResult is valid.
- OutReady  input  1  downstream accepts OutResult.
- OutResult  output  ELEM_WIDTH  reduced scalar.
- OutZero  output  1  high when OutResult == 0; meaningful only while OutValid is high.
- Busy  output  1  high in ACCUM or DONE.

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE.
  - InReady = 1, OutValid = 0, Busy = 0, OutResult = 0, OutZero = 0.
  - Lane index, accumulator and captured op/vector are all cleared.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - InReady = 1.
  - On an edge with InValid && InReady: capture InVec and RedOp into internal registers, set acc = lane 0, set idx = 1.
  - Next state is ACCUM, or DONE if NUM_ELEMS == 1.
  - InVec and RedOp are don't-care after the accepting edge.
- ACCUM:
  - InReady = 0, Busy = 1.
  - Each edge: acc = f(acc, lane[idx]), then idx = idx + 1.
  - On the edge that combines lane NUM_ELEMS-1, move to DONE.
  - No early exit.
- Combining function f:
  - SUM: acc + lane, modulo 2^ELEM_WIDTH; carry and overflow are discarded.
  - MAX: larger of the two values, compared as two's-complement signed.
  - MIN: smaller of the two values, compared as two's-complement signed.
  - OR: bitwise OR.
  - Ties in MAX/MIN give the same value, so tie order does not matter.
- DONE:
  - OutValid = 1, OutResult = acc, OutZero = (acc == 0), InReady = 0.
  - OutResult and OutZero stay stable until the handshake.
  - On an edge with OutValid && OutReady: go to IDLE and drop OutValid.
  - OutResult holds its last value; it is not cleared.
- Latency: OutValid is first high after NUM_ELEMS-1 rising edges following the accepting edge (7 edges at the default).
- Throughput: one vector per NUM_ELEMS+1 cycles minimum.
  - DONE-to-IDLE costs one cycle.
  - No combinational path from OutReady to InReady.
- OutReady held low: the block stalls in DONE indefinitely without losing data.
- InValid while not in IDLE: ignored. Upstream must hold InValid and its data until InReady is seen high.
- idx counter width is clog2(NUM_ELEMS), minimum 1 bit. It never wraps during a valid operation and is reset to 0 on entry to IDLE.
- Reset asserted mid-ACCUM or mid-DONE: the operation is aborted immediately, no output is produced, and all outputs return to reset values.
- RedOp codes are fully decoded; there is no illegal value.

Test Plan:
- SUM with lanes 1,2,3,4,5,6,7,8, OutReady held high:
  - OutValid rises 7 edges after acceptance, with OutResult = 36 and OutZero = 0.
  - OutValid is high for exactly one cycle.
- MAX/MIN with lanes 0xFFFFFFFF(-1), 5, 0x80000000, 0x7FFFFFFF, 0, 3, -7, 2:
  - MAX gives 0x7FFFFFFF.
  - MIN gives 0x80000000.
  - Both confirm signed comparison.
- SUM wrap with lanes 0xFFFFFFFF,1,0,0,0,0,0,0:
  - OutResult = 0 and OutZero = 1.
  - OR of lanes 0x1,0x2,...,0x80 (one bit each) gives 0xFF.
- Backpressure: hold OutReady = 0 for 20 cycles after OutValid.
  - OutResult stays constant and InReady stays 0.
  - A second InValid pulse during the stall is not accepted.
  - After OutReady goes high, InReady = 1 on the next cycle and the second vector is accepted.
- Back-to-back: InValid held high with two queued vectors, OutReady = 1.
  - Acceptances are exactly NUM_ELEMS+1 = 9 cycles apart.
  - Each result matches the expected value for its vector.
  - RedOp is changed after acceptance and the in-flight result is unaffected.
- Reset: assert rst_n = 0 asynchronously mid-edge at idx = 4 of a SUM.
  - Outputs return to reset values immediately, without waiting for a clock edge.
  - After release, a new SUM of all-zero lanes gives OutResult = 0 and OutZero = 1, with no stale accumulator value.
